// File: rtl/phys_tag_release_queue_pkg.sv
// Shared rename / free-list types.
// Tag width and the release bundle seen by the free list.
package phys_tag_release_queue_pkg;

    localparam int NUM_PHYS = 32;
    localparam int TAG_W    = $clog2(NUM_PHYS);

    typedef logic [TAG_W-1:0] ptag_t;

    typedef struct packed {
        logic [2:0]  en;
        ptag_t [2:0] tag;
    } rel_bundle_t;

endpackage

// File: rtl/phys_tag_release_queue_release_compactor.sv
// Packs the qualified commit slots, in slot order,
// into consecutive lanes and counts them.
module release_compactor
    import phys_tag_release_queue_pkg::*;
(
    input  logic [2:0]  slot_v,
    input  ptag_t [2:0] slot_tag,
    output ptag_t [2:0] tags,
    output logic [1:0]  n_in
);

    logic [1:0] cnt;

    always_comb begin
        tags = '0;
        cnt  = '0;
        for (int i = 0; i < 3; i++) begin
            if (slot_v[i]) begin
                tags[cnt] = slot_tag[i];
                cnt       = cnt + 2'd1;
            end
        end
        n_in = cnt;
    end

endmodule

// File: rtl/phys_tag_release_queue.sv
// Stages tags freed at commit and drains them, in order,
// into the free list's three write ports.
module phys_tag_release_queue
    import phys_tag_release_queue_pkg::*;
#(
    parameter int Q_DEPTH = 8,
    localparam int QPTR_W = $clog2(Q_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_valid_0,
    input  logic              commit_valid_1,
    input  logic              commit_valid_2,
    input  logic              commit_has_dest_0,
    input  logic              commit_has_dest_1,
    input  logic              commit_has_dest_2,
    input  logic [TAG_W-1:0]  commit_tag_0,
    input  logic [TAG_W-1:0]  commit_tag_1,
    input  logic [TAG_W-1:0]  commit_tag_2,
    output logic              commit_ready,
    input  logic [TAG_W:0]    fl_space,
    output logic              rel_en_0,
    output logic              rel_en_1,
    output logic              rel_en_2,
    output logic [TAG_W-1:0]  rel_tag_0,
    output logic [TAG_W-1:0]  rel_tag_1,
    output logic [TAG_W-1:0]  rel_tag_2,
    output logic [QPTR_W:0]   q_count,
    output logic              q_empty,
    output logic              overflow_err
);

    localparam logic [QPTR_W:0] DEPTH_V = (QPTR_W+1)'(Q_DEPTH);
    localparam logic [QPTR_W:0] THREE_Q = (QPTR_W+1)'(3);
    localparam logic [TAG_W:0]  THREE_F = (TAG_W+1)'(3);

    ptag_t             mem [Q_DEPTH];
    logic [QPTR_W:0]   rd_ptr;
    logic [QPTR_W:0]   wr_ptr;
    logic [QPTR_W:0]   count;
    logic [QPTR_W-1:0] rd_idx;
    logic [QPTR_W-1:0] wr_idx;
    logic [2:0]        slot_v;
    ptag_t [2:0]       slot_tag;
    ptag_t [2:0]       in_tags;
    logic [1:0]        n_in;
    logic [1:0]        cnt3;
    logic [1:0]        spc3;
    logic [1:0]        n_out;
    logic              enq;
    rel_bundle_t       rel;

    assign slot_v = {commit_valid_2 & commit_has_dest_2,
                     commit_valid_1 & commit_has_dest_1,
                     commit_valid_0 & commit_has_dest_0};
    assign slot_tag = {commit_tag_2, commit_tag_1, commit_tag_0};

    release_compactor u_compact (
        .slot_v   (slot_v),
        .slot_tag (slot_tag),
        .tags     (in_tags),
        .n_in     (n_in)
    );

    assign count  = wr_ptr - rd_ptr;
    assign rd_idx = rd_ptr[QPTR_W-1:0];
    assign wr_idx = wr_ptr[QPTR_W-1:0];

    // Readiness deliberately ignores this cycle's drain.
    assign commit_ready = (DEPTH_V - count) >= THREE_Q;
    assign enq          = commit_ready && (n_in != 2'd0);

    assign cnt3  = (count >= THREE_Q) ? 2'd3 : count[1:0];
    assign spc3  = (fl_space >= THREE_F) ? 2'd3 : fl_space[1:0];
    assign n_out = (cnt3 < spc3) ? cnt3 : spc3;

    always_comb begin
        rel = '0;
        for (int k = 0; k < 3; k++) begin
            rel.en[k] = 2'(k) < n_out;
            if (rel.en[k]) begin
                rel.tag[k] = mem[rd_idx + QPTR_W'(k)];
            end
        end
    end

    assign {rel_en_2, rel_en_1, rel_en_0}    = rel.en;
    assign {rel_tag_2, rel_tag_1, rel_tag_0} = rel.tag;
    assign q_count = count;
    assign q_empty = (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + (QPTR_W+1)'(n_out);
            if (enq) begin
                wr_ptr <= wr_ptr + (QPTR_W+1)'(n_in);
            end
            if (!commit_ready && (n_in != 2'd0)) begin
                overflow_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < Q_DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (enq) begin
            for (int k = 0; k < 3; k++) begin
                if (2'(k) < n_in) begin
                    mem[wr_idx + QPTR_W'(k)] <= in_tags[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_phys_tag_release_queue.sv
// Directed checks for the freed-tag staging queue.
// Expected values are worked out by hand per step.
module tb_phys_tag_release_queue;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cv0, cv1, cv2;
    logic       cd0, cd1, cd2;
    logic [4:0] ct0, ct1, ct2;
    logic       commit_ready;
    logic [5:0] fl_space;
    logic       re0, re1, re2;
    logic [4:0] rt0, rt1, rt2;
    logic [3:0] q_count;
    logic       q_empty;
    logic       overflow_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    phys_tag_release_queue dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .commit_valid_0    (cv0),
        .commit_valid_1    (cv1),
        .commit_valid_2    (cv2),
        .commit_has_dest_0 (cd0),
        .commit_has_dest_1 (cd1),
        .commit_has_dest_2 (cd2),
        .commit_tag_0      (ct0),
        .commit_tag_1      (ct1),
        .commit_tag_2      (ct2),
        .commit_ready      (commit_ready),
        .fl_space          (fl_space),
        .rel_en_0          (re0),
        .rel_en_1          (re1),
        .rel_en_2          (re2),
        .rel_tag_0         (rt0),
        .rel_tag_1         (rt1),
        .rel_tag_2         (rt2),
        .q_count           (q_count),
        .q_empty           (q_empty),
        .overflow_err      (overflow_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic commit(input logic [2:0] v, input logic [2:0] d,
                          input logic [4:0] t0, input logic [4:0] t1,
                          input logic [4:0] t2);
        {cv2, cv1, cv0} = v;
        {cd2, cd1, cd0} = d;
        ct0 = t0;
        ct1 = t1;
        ct2 = t2;
    endtask

    task automatic idle();
        commit(3'b000, 3'b000, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(commit_ready), 32'd1);
        chk({tag, "_empty"}, 32'(q_empty), 32'd1);
        chk({tag, "_count"}, 32'(q_count), 32'd0);
        chk({tag, "_en"}, 32'({re2, re1, re0}), 32'd0);
        chk({tag, "_tags"}, 32'({rt2, rt1, rt0}), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow_err), 32'd0);
    endtask

    task automatic chk_rel(input string tag, input logic [2:0] en,
                           input logic [4:0] t0, input logic [4:0] t1,
                           input logic [4:0] t2);
        chk({tag, "_en"}, 32'({re2, re1, re0}), 32'(en));
        chk({tag, "_t0"}, 32'(rt0), 32'(t0));
        chk({tag, "_t1"}, 32'(rt1), 32'(t1));
        chk({tag, "_t2"}, 32'(rt2), 32'(t2));
    endtask

    initial begin
        rst_n    = 1'b0;
        fl_space = 6'd32;
        idle();
        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        step();
        chk_reset("idle");

        // compaction skips the slot without a valid retire
        commit(3'b101, 3'b111, 5'd5, 5'd9, 5'd12);
        step();
        idle();
        chk_rel("cmp", 3'b011, 5'd5, 5'd12, 5'd0);
        chk("cmp_count", 32'(q_count), 32'd2);
        step();
        chk("cmp_empty", 32'(q_empty), 32'd1);
        chk_rel("cmp_drained", 3'b000, 5'd0, 5'd0, 5'd0);

        // preload six tags with the free list held full
        fl_space = 6'd0;
        commit(3'b111, 3'b111, 5'd10, 5'd11, 5'd12);
        step();
        commit(3'b111, 3'b111, 5'd13, 5'd14, 5'd15);
        step();
        idle();
        chk("pre_count", 32'(q_count), 32'd6);
        chk("pre_ready", 32'(commit_ready), 32'd0);
        fl_space = 6'd2;
        #1;
        chk_rel("sp2_a", 3'b011, 5'd10, 5'd11, 5'd0);
        step();
        chk_rel("sp2_b", 3'b011, 5'd12, 5'd13, 5'd0);
        step();
        fl_space = 6'd0;
        #1;
        chk_rel("sp0", 3'b000, 5'd0, 5'd0, 5'd0);
        chk("sp0_count", 32'(q_count), 32'd2);
        step();
        chk("sp0_hold", 32'(q_count), 32'd2);

        // fill to six, then push into a full queue
        commit(3'b111, 3'b111, 5'd20, 5'd21, 5'd22);
        step();
        commit(3'b001, 3'b001, 5'd23, 5'd0, 5'd0);
        step();
        chk("fill_count", 32'(q_count), 32'd6);
        chk("fill_ready", 32'(commit_ready), 32'd0);
        chk("fill_ovf", 32'(overflow_err), 32'd0);
        commit(3'b111, 3'b111, 5'd30, 5'd31, 5'd1);
        step();
        idle();
        chk("ovf_set", 32'(overflow_err), 32'd1);
        chk("ovf_count", 32'(q_count), 32'd6);
        fl_space = 6'd32;
        #1;
        chk_rel("ovf_d1", 3'b111, 5'd14, 5'd15, 5'd20);
        step();
        chk_rel("ovf_d2", 3'b111, 5'd21, 5'd22, 5'd23);
        step();
        chk("ovf_empty", 32'(q_empty), 32'd1);
        chk("ovf_sticky", 32'(overflow_err), 32'd1);

        // streaming 3-in / 3-out across pointer wrap
        for (int c = 0; c < 20; c++) begin
            commit(3'b111, 3'b111, 5'((3*c) % 32),
                   5'((3*c+1) % 32), 5'((3*c+2) % 32));
            step();
            chk_rel("stream", 3'b111, 5'((3*c) % 32),
                    5'((3*c+1) % 32), 5'((3*c+2) % 32));
            chk("stream_count", 32'(q_count), 32'd3);
        end
        idle();
        step();
        chk("stream_empty", 32'(q_empty), 32'd1);
        chk("stream_ovf", 32'(overflow_err), 32'd1);

        // asynchronous reset with five tags queued
        fl_space = 6'd0;
        commit(3'b111, 3'b111, 5'd1, 5'd2, 5'd3);
        step();
        commit(3'b011, 3'b011, 5'd4, 5'd5, 5'd0);
        step();
        idle();
        chk("pre_rst_count", 32'(q_count), 32'd5);
        fl_space = 6'd32;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        @(negedge clk);
        rst_n = 1'b1;
        commit(3'b010, 3'b011, 5'd9, 5'd7, 5'd0);
        step();
        idle();
        chk_rel("post_rst", 3'b001, 5'd7, 5'd0, 5'd0);
        step();
        chk("post_rst_empty", 32'(q_empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
